// File: rtl/bus_mailbox_responder.sv
// rtl/bus_mailbox_responder.sv - CPU mailbox responder bridging bus registers to TX/RX stream FIFOs
module mailbox_fifo #(
    parameter int Depth = 16,
    parameter int Width = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [Width-1:0]        wdata,
    output logic [Width-1:0]        head,
    output logic [$clog2(Depth):0]  count,
    output logic                    empty,
    output logic                    full
);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(Depth));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

module bus_mailbox_responder #(
    parameter int unsigned BaseAddress  = 32'h9000,
    parameter int          AddressWidth = 16,
    parameter int          DataWidth    = 32,
    parameter int          FifoDepth    = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    bus_we_i,
    input  logic [AddressWidth-1:0] bus_address_i,
    input  logic [DataWidth-1:0]    bus_data_i,
    output logic [DataWidth-1:0]    bus_data_o,
    output logic [DataWidth-1:0]    tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    input  logic [DataWidth-1:0]    rx_data_i,
    input  logic                    rx_valid_i,
    output logic                    rx_ready_o,
    output logic                    irq_o
);
    localparam int CW = $clog2(FifoDepth) + 1;

    logic                 hit;
    logic [2:0]           offset;
    logic                 wr_hit;
    logic                 rd_hit;
    logic                 tx_push_req;
    logic                 rx_pop_req;
    logic                 ctrl_wr;
    logic                 tx_flush;
    logic                 rx_flush;
    logic                 sticky_clr;
    logic                 tx_ovf;
    logic                 rx_unf;
    logic                 tx_ovf_q;
    logic                 rx_unf_q;
    logic                 irq_en;
    logic [DataWidth-1:0] tx_head;
    logic [DataWidth-1:0] rx_head;
    logic [CW-1:0]        tx_count;
    logic [CW-1:0]        rx_count;
    logic                 tx_empty;
    logic                 tx_full;
    logic                 rx_empty;
    logic                 rx_full;
    logic [DataWidth-1:0] rdata;

    assign hit    = (bus_address_i >= AddressWidth'(BaseAddress)) &&
                    (bus_address_i <= AddressWidth'(BaseAddress + 4));
    assign offset = 3'(bus_address_i - AddressWidth'(BaseAddress));
    assign wr_hit = hit & bus_we_i;
    assign rd_hit = hit & ~bus_we_i;

    assign tx_push_req = wr_hit & (offset == 3'd1);
    assign rx_pop_req  = rd_hit & (offset == 3'd2);
    assign ctrl_wr     = wr_hit & (offset == 3'd3);
    assign tx_flush    = ctrl_wr & bus_data_i[0];
    assign rx_flush    = ctrl_wr & bus_data_i[1];
    assign sticky_clr  = ctrl_wr & bus_data_i[3];

    // A full TX FIFO always has a head, so tx_ready_i alone decides whether a slot frees up.
    assign tx_ovf = tx_push_req & tx_full & ~tx_ready_i;
    assign rx_unf = rx_pop_req & rx_empty;

    mailbox_fifo #(.Depth(FifoDepth), .Width(DataWidth)) u_tx_fifo (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .push  (tx_push_req),
        .pop   (tx_ready_i),
        .flush (tx_flush),
        .wdata (bus_data_i),
        .head  (tx_head),
        .count (tx_count),
        .empty (tx_empty),
        .full  (tx_full)
    );

    mailbox_fifo #(.Depth(FifoDepth), .Width(DataWidth)) u_rx_fifo (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .push  (rx_valid_i),
        .pop   (rx_pop_req),
        .flush (rx_flush),
        .wdata (rx_data_i),
        .head  (rx_head),
        .count (rx_count),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign tx_data_o  = tx_head;
    assign tx_valid_o = ~tx_empty;
    assign rx_ready_o = ~rx_full;

    always_comb begin
        rdata = '0;
        case (offset)
            3'd0: rdata[5:0] = {rx_unf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
            3'd2: rdata = rx_empty ? '0 : rx_head;
            3'd3: rdata[2] = irq_en;
            3'd4: begin
                rdata[15:0]  = 16'(tx_count);
                rdata[31:16] = 16'(rx_count);
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bus_data_o <= '0;
            tx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            irq_en     <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            bus_data_o <= rd_hit ? rdata : '0;
            // Clear first so a coincident set wins.
            tx_ovf_q   <= tx_ovf | (tx_ovf_q & ~sticky_clr);
            rx_unf_q   <= rx_unf | (rx_unf_q & ~sticky_clr);
            if (ctrl_wr) irq_en <= bus_data_i[2];
            irq_o      <= irq_en & (~rx_empty | tx_ovf_q | rx_unf_q);
        end
    end
endmodule

// File: tb/tb_bus_mailbox_responder.sv
// tb/tb_bus_mailbox_responder.sv - randomized queue-model bench for bus_mailbox_responder
module tb_bus_mailbox_responder;
    localparam int BASE  = 'h9000;
    localparam int DEPTH = 16;

    logic        clk = 0;
    logic        reset_n = 1;
    logic        bus_we = 0;
    logic [15:0] bus_address = 0;
    logic [31:0] bus_wdata = 0;
    logic [31:0] bus_rdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 0;
    logic [31:0] rx_data = 0;
    logic        rx_valid = 0;
    logic        rx_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit          m_txo, m_rxu, m_irq_en;
    logic [31:0] exp_bus;
    logic        exp_irq;

    bus_mailbox_responder #(
        .BaseAddress(BASE), .AddressWidth(16), .DataWidth(32), .FifoDepth(DEPTH)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .bus_we_i      (bus_we),
        .bus_address_i (bus_address),
        .bus_data_i    (bus_wdata),
        .bus_data_o    (bus_rdata),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_ready_o    (rx_ready),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_txo = 0;
        m_rxu = 0;
        m_irq_en = 0;
        exp_bus = 0;
        exp_irq = 0;
    endtask

    // Effect of the coming clock edge given the current inputs and model state.
    task automatic model_step();
        logic [31:0] rd;
        bit hit, ovf, unf, nirq;
        int off;
        off = int'(bus_address) - BASE;
        hit = (off >= 0) && (off <= 4);
        rd = 0;
        if (hit && !bus_we) begin
            case (off)
                0: begin
                    rd[0] = (tx_q.size() == 0);
                    rd[1] = (tx_q.size() == DEPTH);
                    rd[2] = (rx_q.size() == 0);
                    rd[3] = (rx_q.size() == DEPTH);
                    rd[4] = m_txo;
                    rd[5] = m_rxu;
                end
                2: rd = (rx_q.size() != 0) ? rx_q[0] : 0;
                3: rd[2] = m_irq_en;
                4: rd = (rx_q.size() << 16) | tx_q.size();
                default: rd = 0;
            endcase
        end
        nirq = m_irq_en && (rx_q.size() != 0 || m_txo || m_rxu);
        ovf = 0;
        unf = 0;
        if (tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
        if (hit && bus_we && off == 1) begin
            if (tx_q.size() < DEPTH) tx_q.push_back(bus_wdata);
            else ovf = 1;
        end
        if (hit && !bus_we && off == 2) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else unf = 1;
        end
        if (rx_valid && rx_q.size() < DEPTH) rx_q.push_back(rx_data);
        if (hit && bus_we && off == 3) begin
            if (bus_wdata[3]) begin
                m_txo = 0;
                m_rxu = 0;
            end
            if (bus_wdata[0]) tx_q.delete();
            if (bus_wdata[1]) rx_q.delete();
            m_irq_en = bus_wdata[2];
        end
        if (ovf) m_txo = 1;
        if (unf) m_rxu = 1;
        exp_bus = rd;
        exp_irq = nirq;
    endtask

    task automatic check_outputs();
        check("bus_data", bus_rdata, exp_bus);
        check("irq", 32'(irq), 32'(exp_irq));
        check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
        check("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
    endtask

    task automatic step(input logic we, input logic [15:0] addr, input logic [31:0] d,
                        input logic txr, input logic rxv, input logic [31:0] rxd);
        bus_we = we;
        bus_address = addr;
        bus_wdata = d;
        tx_ready = txr;
        rx_valid = rxv;
        rx_data = rxd;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic bus_write(input int off, input logic [31:0] d);
        step(1, 16'(BASE + off), d, 0, 0, 0);
    endtask

    task automatic bus_read(input int off);
        step(0, 16'(BASE + off), 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_step();
        int r;
        logic [15:0] a;
        logic [31:0] d;
        r = $urandom_range(0, 9);
        if (r == 0)      a = 0;
        else if (r == 1) a = 16'(BASE - 1);
        else if (r == 2) a = 16'(BASE + 5);
        else             a = 16'(BASE + (r - 3) % 5);
        d = $urandom;
        if (a == 16'(BASE + 3) && $urandom_range(0, 3) != 0) d[1:0] = 2'b00;
        step(a != 0 && $urandom_range(0, 1) == 1, a, d,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_bus"}, bus_rdata, 0);
        check({tag, "_txv"}, 32'(tx_valid), 0);
        check({tag, "_rxr"}, 32'(rx_ready), 1);
        check({tag, "_irq"}, 32'(irq), 0);
    endtask

    initial begin
        model_reset();
        #2 reset_n = 0;
        #1 reset_check("por");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // single TX beat
        step(1, 16'(BASE + 1), 32'hA5, 1, 0, 0);
        check("t2_txd", tx_data, 32'hA5);
        check("t2_txv", 32'(tx_valid), 1);
        step(0, 0, 0, 1, 0, 0);
        check("t2_empty", 32'(tx_valid), 0);

        // two RX entries read back in order
        step(0, 0, 0, 0, 1, 32'h11);
        step(0, 0, 0, 0, 1, 32'h22);
        bus_read(2);
        check("t3_first", bus_rdata, 32'h11);
        idle();
        check("t3_gap", bus_rdata, 0);
        bus_read(2);
        check("t3_second", bus_rdata, 32'h22);
        idle();

        // TX overflow and sticky clear
        for (int i = 0; i < 17; i++) bus_write(1, 32'h100 + i);
        bus_read(4);
        check("t4_levels", bus_rdata & 32'hFFFF, 16);
        bus_read(0);
        check("t4_ovf", 32'(bus_rdata[4]), 1);
        bus_write(3, 32'h8);
        bus_read(0);
        check("t4_ovf_clr", 32'(bus_rdata[4]), 0);

        // level interrupt
        bus_write(3, 32'h4);
        step(0, 0, 0, 0, 1, 32'h77);
        idle();
        check("t5_irq_set", 32'(irq), 1);
        bus_read(2);
        check("t5_pop", bus_rdata, 32'h77);
        idle();
        check("t5_irq_clr", 32'(irq), 0);

        // full RX with coincident push and pop
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 32'h200 + i);
        check("t6_full", 32'(rx_ready), 0);
        step(0, 16'(BASE + 2), 0, 0, 1, 32'hBEEF);
        check("t6_head", bus_rdata, 32'h200);
        bus_read(4);
        check("t6_count", bus_rdata >> 16, 16);

        bus_write(3, 32'hF);
        for (int i = 0; i < 2000; i++) random_step();

        // reset in the middle of traffic
        bus_we = 1;
        bus_address = 16'(BASE + 1);
        bus_wdata = $urandom;
        rx_valid = 1;
        tx_ready = 1;
        #2 reset_n = 0;
        #1 reset_check("mid");
        model_reset();
        @(negedge clk);
        reset_n = 1;
        bus_we = 0;
        bus_address = 0;
        rx_valid = 0;
        tx_ready = 0;
        for (int i = 0; i < 300; i++) random_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
